// File: rtl/logic_unit_n.sv
// logic_unit_n: handshaked bitwise logic unit with iterative popcount / Hamming distance
module logic_unit_n #(
   parameter int REGISTER_LENGTH = 64,
   parameter int CHUNK           = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   input  logic [2:0]                 op_i,
   input  logic [REGISTER_LENGTH-1:0] A_i,
   input  logic [REGISTER_LENGTH-1:0] B_i,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [REGISTER_LENGTH-1:0] out_o,
   output logic                       zero_o,
   output logic                       parity_o
);
   localparam int N  = REGISTER_LENGTH;
   localparam int K  = N / CHUNK;
   localparam int AW = $clog2(N + 1);
   localparam int CW = (K > 1) ? $clog2(K) : 1;

   if (CHUNK < 1 || N < CHUNK || (N % CHUNK) != 0) begin : g_bad_chunk
      $error("logic_unit_n: CHUNK must be >= 1 and divide REGISTER_LENGTH");
   end

   typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    shift_q, shift_d;
   logic [AW-1:0]   acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N-1:0]    out_q, out_d;
   logic            zero_q, zero_d;
   logic            parity_q, parity_d;
   logic [N-1:0]    logic_res;
   logic [AW-1:0]   chunk_pc;
   logic [AW-1:0]   acc_sum;
   logic            is_count;
   logic            last_chunk;

   assign is_count   = op_i[2] & op_i[1];
   assign last_chunk = cnt_q == CW'(K - 1);
   assign acc_sum    = acc_q + chunk_pc;

   assign ready_o  = state_q == IDLE;
   assign valid_o  = state_q == DONE;
   assign out_o    = out_q;
   assign zero_o   = zero_q;
   assign parity_o = parity_q;

   // single-cycle bitwise result for the six gate operations
   always_comb begin
      logic_res = '0;
      unique case (op_i)
         3'b000:  logic_res = A_i & B_i;
         3'b001:  logic_res = A_i | B_i;
         3'b010:  logic_res = A_i ^ B_i;
         3'b011:  logic_res = ~(A_i ^ B_i);
         3'b100:  logic_res = ~(A_i | B_i);
         3'b101:  logic_res = A_i & ~B_i;
         default: logic_res = '0;
      endcase
   end

   // population count of the chunk currently at the bottom of the shift register
   always_comb begin
      chunk_pc = '0;
      for (int i = 0; i < CHUNK; i++) chunk_pc = chunk_pc + AW'(shift_q[i]);
   end

   // next-state and datapath updates; result registers only change at completion
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      out_d    = out_q;
      zero_d   = zero_q;
      parity_d = parity_q;
      case (state_q)
         IDLE: begin
            if (valid_i && is_count) begin
               shift_d = op_i[0] ? A_i : (A_i ^ B_i);
               acc_d   = '0;
               cnt_d   = '0;
               state_d = COUNT;
            end else if (valid_i) begin
               out_d    = logic_res;
               zero_d   = ~|logic_res;
               parity_d = ^logic_res;
               state_d  = DONE;
            end
         end
         COUNT: begin
            acc_d   = acc_sum;
            shift_d = shift_q >> CHUNK;
            cnt_d   = cnt_q + CW'(1);
            if (last_chunk) begin
               out_d    = N'(acc_sum);
               zero_d   = acc_sum == '0;
               parity_d = acc_sum[0];
               state_d  = DONE;
            end
         end
         DONE:    state_d = ready_i ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end

   // state and result registers, cleared asynchronously so reset discards any operation
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         out_q    <= '0;
         zero_q   <= 1'b0;
         parity_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         out_q    <= out_d;
         zero_q   <= zero_d;
         parity_q <= parity_d;
      end
   end
endmodule

// File: doc/logic_unit_n.md
# logic_unit_n

Parametrised, handshaked bitwise logic unit for the CPU execute stage. It is the successor to the fixed-function N-bit gate arrays. A single registered block performs AND/OR/XOR/XNOR/NOR/ANDN in one cycle, and population count / Hamming distance iteratively, CHUNK bits per cycle. Results carry zero and parity flags and are held under valid/ready back-pressure until the consumer takes them.

## Interface
Parameters:
- REGISTER_LENGTH, 64: operand width N. Must be ≥ CHUNK.
- CHUNK, 8: bits counted per cycle in count ops. Must divide REGISTER_LENGTH; any other value is an elaboration error.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  reset. Asynchronous, active-low.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept a request. High iff state is IDLE.
- op_i  in  3  operation select.
- A_i  in  N  operand A.
- B_i  in  N  operand B.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts the result.
- out_o  out  N  result.
- zero_o  out  1  out_o == 0.
- parity_o  out  1  XOR-reduction of the logic result; for count ops, count[0].

## Operation
- op_i encoding:
  - 000 AND, 001 OR, 010 XOR, 011 XNOR, 100 NOR, 101 ANDN (A & ~B).
  - 110 HAMM: popcount(A ^ B). 111 POPC: popcount(A).
- States: IDLE, COUNT, DONE.
- IDLE, with valid_i high (accept):
  - Logic op: the result is registered into out_o, the flags are computed from it, and the state goes to DONE.
  - Count op: the shift register is loaded with A^B (HAMM) or A (POPC), the accumulator is cleared, the chunk counter is cleared, and the state goes to COUNT.
- COUNT, each cycle:
  - The accumulator adds the popcount of the low CHUNK bits of the shift register.
  - The shift register shifts right by CHUNK.
  - The chunk counter increments.
  - After K = N/CHUNK such cycles, out_o is loaded with the accumulator zero-extended to N, the flags are set, and the state goes to DONE.
- Widths:
  - Accumulator is clog2(N+1) bits, so no overflow is possible.
  - Chunk counter is clog2(K) bits, minimum 1.
- DONE: valid_o is high. out_o, zero_o and parity_o hold stable until valid_o && ready_i, then the state goes to IDLE.
- Inputs (valid_i, op_i, A_i, B_i) are ignored whenever ready_o is low. Operands are sampled only at accept.
- ready_o is low in COUNT and DONE. There is no same-cycle accept while in DONE.

## Timing
- Reset (rst_n_i low), effective immediately and asynchronously:
  - state = IDLE, out_o = 0, valid_o = 0, zero_o = 0, parity_o = 0.
  - ready_o = 1 (state is IDLE), but valid_i is ignored while rst_n_i is low.
- Logic op latency: accept on edge 0, valid_o high after edge 0. That is 1 cycle.
- Count op latency: accept on edge 0, COUNT edges 1..K, valid_o high after edge K. For N = 64 and CHUNK = 8 this is 8 cycles.
- Throughput: one result per (latency + 1) cycles at best. The handshake cycle in DONE returns to IDLE.
- Back-pressure: while valid_o is high and ready_i is low, every output is bit-stable.
- Reset mid-COUNT or mid-DONE: the operation is discarded and the state returns to IDLE. No result is emitted after release.
- Unused op encodings: none; all 8 are defined.

## Test plan
- Reset: assert rst_n_i low mid-cycle.
  - Required: out_o, valid_o, zero_o and parity_o are 0 without waiting for a clock edge, and ready_o is 1.
  - Pulse valid_i during reset. Required: valid_o stays 0.
- XOR: A = 0xFFFF0000FFFF0000, B = 0x0F0F0F0F0F0F0F0F.
  - Required: out_o = 0xF0F00F0FF0F00F0F one cycle after accept, zero_o = 0, parity_o = 0.
  - Then AND with B = 0. Required: out_o = 0, zero_o = 1.
- XNOR with A = B = 0x123456789ABCDEF0.
  - Required: out_o = 0xFFFFFFFFFFFFFFFF, parity_o = 0.
  - ANDN with A = 0xFF, B = 0x0F. Required: out_o = 0xF0, parity_o = 0.
- Count ops:
  - HAMM with A = all ones, B = 0. Required: ready_o low for 8 cycles, then valid_o with out_o = 64, parity_o = 0.
  - POPC with A = 0x8000000000000001. Required: out_o = 2.
  - POPC with A = 0x7. Required: out_o = 3, parity_o = 1.
- Back-pressure: hold ready_i low for 5 cycles after valid_o, and toggle valid_i, A_i and op_i during that time.
  - Required: out_o and the flags are unchanged and ready_o = 0.
  - On ready_i high: valid_o drops next cycle and ready_o rises.
- Reset mid-COUNT: start HAMM, then drop rst_n_i after COUNT edge 4.
  - Required: valid_o = 0 and ready_o = 1 after release.
  - A following XOR completes normally with the correct result.
